// File: rtl/ioctl_upload_reader.sv
// HPS upload responder: fetches bytes from core memory through an arbitrated read port
// and presents them on ioctl_din. Optional macro UPLOAD_CHECKSUM_EN adds a running byte checksum.
module ioctl_upload_reader #(
  parameter int          MEM_LAT   = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] LEN       = 16'h8000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_q,
  output logic        upload_busy,
  output logic        upload_done,
`ifdef UPLOAD_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_LAT,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [15:0] r_ptr;
  logic [15:0] r_count;
  logic [7:0]  r_din;
  logic        r_wait;
  logic        r_mem_rd;
  logic [15:0] r_mem_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_upload_prev;
  logic [2:0]  r_lat_cnt;
  logic [7:0]  r_sum;

  logic [15:0] w_ptr_next;

  assign w_ptr_next = r_ptr + 16'd1;

  // The request is launched in the same edge that accepts ioctl_rd so that an
  // immediately granted read returns data MEM_LAT+2 cycles after the pulse.
  // S_FETCH is only entered for offsets past LEN, where no memory access happens.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= 16'd0;
      r_count       <= 16'd0;
      r_din         <= 8'd0;
      r_wait        <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= 16'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_lat_cnt     <= 3'd0;
      r_sum         <= 8'd0;
      // Tracking the live level keeps an upload raised during reset from starting.
      r_upload_prev <= ioctl_upload;
    end else begin
      r_upload_prev <= ioctl_upload;
      r_done        <= 1'b0;
      if (r_state != S_IDLE && !ioctl_upload) begin
        r_state  <= S_IDLE;
        r_mem_rd <= 1'b0;
        r_wait   <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ioctl_upload && !r_upload_prev) begin
              r_ptr      <= 16'd0;
              r_count    <= 16'd0;
              r_sum      <= 8'd0;
              r_busy     <= 1'b1;
              r_wait     <= 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= BASE_ADDR;
              r_state    <= S_REQ;
            end
          end
          S_FETCH: begin
            r_din   <= 8'hFF;
            r_wait  <= 1'b0;
            r_state <= S_HOLD;
          end
          S_REQ: begin
            if (mem_grant) begin
              r_mem_rd  <= 1'b0;
              r_lat_cnt <= 3'(MEM_LAT - 1);
              r_state   <= S_LAT;
            end
          end
          S_LAT: begin
            if (r_lat_cnt == 3'd0) begin
              r_din   <= mem_q;
              r_wait  <= 1'b0;
              r_state <= S_HOLD;
            end else begin
              r_lat_cnt <= r_lat_cnt - 3'd1;
            end
          end
          S_HOLD: begin
            if (ioctl_rd) begin
              r_ptr   <= w_ptr_next;
              r_count <= r_count + 16'd1;
              r_sum   <= r_sum + r_din;
              r_wait  <= 1'b1;
              if (w_ptr_next >= LEN) begin
                r_state <= S_FETCH;
              end else begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= BASE_ADDR + w_ptr_next;
                r_state    <= S_REQ;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_din   = r_din;
  assign ioctl_wait  = r_wait;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign upload_busy = r_busy;
  assign upload_done = r_done;
  assign byte_count  = r_count;

`ifdef UPLOAD_CHECKSUM_EN
  assign checksum = r_sum;
`else
  logic w_sum_unused;
  assign w_sum_unused = ^r_sum;
`endif

endmodule

// File: doc/ioctl_upload_reader.md
Name: ioctl_upload_reader

Overview:
- HPS-upload responder: the read-direction counterpart of the ioctl download path that loads cartridges.
- While the HPS runs an upload (save of cartridge RAM or a memory dump), the block fetches bytes from core memory through an arbitrated read port.
- It presents each byte on ioctl_din and holds ioctl_wait high until the byte is valid.
- It sits beside hps_io in the emu top, clocked on clk_sys, and shares the RAM with the CPU via an external arbiter.

Parameters:
- MEM_LAT, 2, cycles from the sampled grant to valid mem_q (1..7).
- BASE_ADDR, 16'h0000, memory address corresponding to upload byte 0.
- LEN, 16'h8000, number of real bytes (1..65535); bytes at offset >= LEN read as 8'hFF.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- reset  in  1  synchronous reset, active high.
- ioctl_upload  in  1  high for the whole HPS upload transfer.
- ioctl_rd  in  1  one-cycle pulse: HPS consumed ioctl_din, advance to the next byte.
- ioctl_din  out  8  byte presented to the HPS.
- ioctl_wait  out  1  high while ioctl_din is not yet valid.
- mem_rd  out  1  read request to the arbiter; held until granted.
- mem_addr  out  16  read address, stable while mem_rd is high.
- mem_grant  in  1  arbiter accepts the request in this cycle.
- mem_q  in  8  read data, valid MEM_LAT cycles after the grant cycle.
- upload_busy  out  1  high from upload start until the upload ends.
- upload_done  out  1  one-cycle pulse after ioctl_upload falls.
- byte_count  out  16  number of ioctl_rd pulses accepted in the current or last upload.

Behaviour:
- Reset (already decided): one clock, clk_sys; reset is synchronous and active-high.
- Reset values: ioctl_din=0, ioctl_wait=0, mem_rd=0, mem_addr=0, upload_busy=0, upload_done=0, byte_count=0, ptr=0, state=IDLE.
- Internal 16-bit offset ptr. mem_addr = BASE_ADDR + ptr, modulo 2^16.
- States:
  - IDLE: on a rising edge of ioctl_upload: ptr=0, byte_count=0, upload_busy=1, ioctl_wait=1, then go to FETCH.
  - FETCH: if ptr >= LEN, skip memory: ioctl_din=8'hFF, ioctl_wait=0 next cycle, go to HOLD. Otherwise drive mem_rd=1 with mem_addr and go to REQ.
  - REQ: mem_rd stays high until mem_grant is sampled high in cycle g. mem_rd=0 in cycle g+1. Load the latency counter and go to LAT.
  - LAT: capture mem_q at the end of cycle g+MEM_LAT. ioctl_din is updated and ioctl_wait=0 in cycle g+MEM_LAT+1. Go to HOLD.
  - HOLD: ioctl_din is held. On ioctl_rd: ptr+1, byte_count+1, ioctl_wait=1 next cycle, go to FETCH.
- Latency: with an immediate grant, ioctl_rd in cycle t gives valid data with ioctl_wait low in cycle t+MEM_LAT+2 (t+4 at the default).
- ioctl_rd while ioctl_wait=1 (protocol violation): ignored; ptr and byte_count unchanged.
- ioctl_upload falls in any state:
  - go to IDLE next cycle;
  - mem_rd=0 and ioctl_wait=0 next cycle;
  - a pending mem_q is discarded;
  - upload_busy=0;
  - upload_done pulses for one cycle;
  - byte_count holds its value.
- ioctl_upload rising in the same cycle that reset is high: reset wins; no upload starts until the next rising edge.
- ptr wraps from 16'hFFFF to 0. Because ptr >= LEN already forces 8'hFF, no memory beyond LEN is ever read.
- mem_grant while mem_rd=0: ignored.

Optional Feature:
- Macro: UPLOAD_CHECKSUM_EN.
- When defined: extra output checksum [7:0].
  - Cleared at upload start.
  - On each accepted ioctl_rd, checksum <= checksum + ioctl_din (the byte being consumed), modulo 256.
  - Holds its value after the upload ends. Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic read (MEM_LAT=2, grant tied high, memory[i]=i XOR 8'h5A, LEN=4): raise ioctl_upload, then pulse ioctl_rd whenever ioctl_wait=0 → HPS sees 5A,5B,58,59,FF,FF; byte_count=6 after the 6th rd; each ioctl_rd at t gives ioctl_wait low at t+4.
- Arbiter stall: hold mem_grant low for 10 cycles on byte 1 → mem_rd and mem_addr=BASE_ADDR+1 stay stable for all 10 cycles; ioctl_wait stays high; data is correct after the grant.
- Abort: drop ioctl_upload in the cycle after grant, mid-LAT → next cycle mem_rd=0, ioctl_wait=0, upload_busy=0; upload_done is a 1-cycle pulse; ioctl_din is not updated by the late mem_q.
- Protocol violation: pulse ioctl_rd while ioctl_wait=1 → ptr and byte_count unchanged; no extra mem_rd is issued.
- Wrap and restart: BASE_ADDR=16'hFFFE, LEN=4 → mem_addr sequence FFFE, FFFF, 0000, 0001. A second upload restarts at FFFE with byte_count=0.
- With UPLOAD_CHECKSUM_EN: bytes 01,02,FF consumed → checksum=8'h02; value is held after upload_done.
